// File: rtl/serial_parity_pkg.sv
// serial_parity_pkg: shared FSM state type and error-counter sizing for the
// serial parity checker.
package serial_parity_pkg;
    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PARITY  = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam int ERR_COUNT_W = 8;
    localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_MAX = 8'd255;
endpackage

// File: rtl/xor_1b.sv
// xor_1b: single-bit XOR cell used to fold each serial bit into the parity
// accumulator.
module xor_1b (
    input  logic A,
    input  logic B,
    output logic C
);
    assign C = A ^ B;
endmodule

// File: rtl/serial_parity_checker.sv
// serial_parity_checker: deserializes LSB-first frames of DATA_BITS data bits
// plus a parity bit and reports the word with a parity-error flag.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_bit,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [DATA_BITS-1:0]   out_data,
    output logic                   out_err,
    input  logic                   out_ready,
    output logic [ERR_COUNT_W-1:0] err_count
);
    localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   acc_q, acc_d, acc_next;
    logic [DATA_BITS-1:0]   shift_q, shift_d, data_q, data_d;
    logic                   err_q, err_d;
    logic [ERR_COUNT_W-1:0] ecnt_q, ecnt_d;
    logic                   accept;

    xor_1b u_xor (.A(acc_q), .B(in_bit), .C(acc_next));

    assign in_ready  = state_q != HOLD;
    assign accept    = in_valid && in_ready;
    assign out_valid = state_q == HOLD;
    assign out_data  = data_q;
    assign out_err   = err_q;
    assign err_count = ecnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        shift_d = shift_q;
        data_d  = data_q;
        err_d   = err_q;
        ecnt_d  = ecnt_q;
        case (state_q)
            COLLECT: if (accept) begin
                shift_d[cnt_q] = in_bit;
                acc_d          = acc_next;
                cnt_d          = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                state_d        = (cnt_q == LAST) ? PARITY : COLLECT;
            end
            PARITY: if (accept) begin
                acc_d   = acc_next;
                data_d  = shift_q;
                err_d   = acc_next;
                state_d = HOLD;
                // Saturate rather than wrap so a flood of bad frames stays visible.
                if (acc_next && ecnt_q != ERR_COUNT_MAX) ecnt_d = ecnt_q + 1'b1;
            end
            HOLD: if (out_ready) begin
                state_d = COLLECT;
                cnt_d   = '0;
                acc_d   = PARITY_ODD;
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            acc_q   <= PARITY_ODD;
            shift_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            ecnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            err_q   <= err_d;
            ecnt_q  <= ecnt_d;
        end
    end
endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: drives an even-parity and an odd-parity instance
// with the same stream and checks both against a word-level parity model.
module tb_serial_parity_checker;
    localparam int DB = 8;

    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_bit = 1'b0, out_ready = 1'b1;
    logic ir_e, ov_e, oe_e, ir_o, ov_o, oe_o;
    logic [DB-1:0] od_e, od_o;
    logic [7:0] ec_e, ec_o;
    int checks = 0, errors = 0;
    int cnt_e = 0, cnt_o = 0;
    logic exp_e, exp_o;
    logic [DB-1:0] exp_w;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_BITS(DB), .PARITY_ODD(1'b0)) dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(ir_e), .out_valid(ov_e), .out_data(od_e), .out_err(oe_e),
        .out_ready(out_ready), .err_count(ec_e));

    serial_parity_checker #(.DATA_BITS(DB), .PARITY_ODD(1'b1)) dut_o (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
        .in_ready(ir_o), .out_valid(ov_o), .out_data(od_o), .out_err(oe_o),
        .out_ready(out_ready), .err_count(ec_o));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; the model is pure word-level parity with saturating counts.
    task automatic send(input logic [DB-1:0] w, input logic p, input bit gaps);
        for (int i = 0; i <= DB; i++) begin
            while (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_bit   = 1'($urandom);
                step();
            end
            in_valid = 1'b1;
            in_bit   = (i < DB) ? w[i] : p;
            step();
        end
        in_valid = 1'b0;
        exp_w = w;
        exp_e = ^{w, p};
        exp_o = ~exp_e;
        if (exp_e && cnt_e < 255) cnt_e++;
        if (exp_o && cnt_o < 255) cnt_o++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++; if (ir_e !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir_e); end
        checks++; if (ov_e !== 1'b0 || ov_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b/%b want 0/0", ov_e, ov_o); end
        checks++; if (od_e !== '0) begin errors++; $display("FAIL reset_out_data got %h want 00", od_e); end
        checks++; if (oe_e !== 1'b0 || oe_o !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b/%b want 0/0", oe_e, oe_o); end
        checks++; if (ec_e !== 8'd0 || ec_o !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d/%0d want 0/0", ec_e, ec_o); end
    endtask

    task automatic test_good_frame();
        out_ready = 1'b1;
        send(8'hA5, 1'b0, 1'b0);
        checks++; if (ov_e !== 1'b1) begin errors++; $display("FAIL good_valid got %b want 1", ov_e); end
        checks++; if (od_e !== 8'hA5) begin errors++; $display("FAIL good_data got %h want a5", od_e); end
        checks++; if (oe_e !== exp_e) begin errors++; $display("FAIL good_err got %b want %b", oe_e, exp_e); end
        checks++; if (oe_o !== exp_o) begin errors++; $display("FAIL good_err_odd got %b want %b", oe_o, exp_o); end
        checks++; if (ec_e !== 8'(cnt_e)) begin errors++; $display("FAIL good_count got %0d want %0d", ec_e, cnt_e); end
        step();
        checks++; if (ov_e !== 1'b0 || ir_e !== 1'b1) begin errors++; $display("FAIL good_one_cycle valid %b ready %b want 0 1", ov_e, ir_e); end
    endtask

    task automatic test_bad_frame();
        send(8'hA5, 1'b1, 1'b0);
        checks++; if (oe_e !== 1'b1 || oe_e !== exp_e) begin errors++; $display("FAIL bad_err got %b want 1", oe_e); end
        checks++; if (ec_e !== 8'(cnt_e)) begin errors++; $display("FAIL bad_count got %0d want %0d", ec_e, cnt_e); end
        checks++; if (oe_o !== exp_o || ec_o !== 8'(cnt_o)) begin errors++; $display("FAIL bad_odd err %b cnt %0d want %b %0d", oe_o, ec_o, exp_o, cnt_o); end
        step();
    endtask

    task automatic test_backpressure();
        logic [DB-1:0] w;
        w = DB'($urandom);
        out_ready = 1'b0;
        send(w, 1'($urandom), 1'b0);
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_bit = 1'($urandom);
            checks++; if (ov_e !== 1'b1 || ir_e !== 1'b0) begin errors++; $display("FAIL bp_hold valid %b ready %b want 1 0", ov_e, ir_e); end
            checks++; if (od_e !== w || oe_e !== exp_e) begin errors++; $display("FAIL bp_stable data %h err %b want %h %b", od_e, oe_e, w, exp_e); end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++; if (ov_e !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", ov_e); end
        send(8'h3C, 1'b0, 1'b0);
        checks++; if (od_e !== 8'h3C || oe_e !== 1'b0) begin errors++; $display("FAIL bp_next data %h err %b want 3c 0", od_e, oe_e); end
        checks++; if (ec_e !== 8'(cnt_e) || ec_o !== 8'(cnt_o)) begin errors++; $display("FAIL bp_count got %0d/%0d want %0d/%0d", ec_e, ec_o, cnt_e, cnt_o); end
        step();
    endtask

    task automatic test_gaps();
        send(8'h81, 1'b0, 1'b1);
        checks++; if (od_e !== 8'h81 || oe_e !== 1'b0) begin errors++; $display("FAIL gaps data %h err %b want 81 0", od_e, oe_e); end
        step();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_bit = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        step();
        rst_n = 1'b1;
        cnt_e = 0;
        cnt_o = 0;
        checks++; if (ec_e !== 8'd0 || ec_o !== 8'd0 || ov_e !== 1'b0) begin errors++; $display("FAIL mid_reset cnt %0d/%0d valid %b want 0/0 0", ec_e, ec_o, ov_e); end
        send(8'hFF, 1'b0, 1'b0);
        checks++; if (od_e !== 8'hFF || oe_e !== 1'b0 || ec_e !== 8'd0) begin errors++; $display("FAIL mid_frame data %h err %b cnt %0d want ff 0 0", od_e, oe_e, ec_e); end
        step();
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) begin
            out_ready = 1'b0;
            send(DB'($urandom), 1'($urandom), 1'b1);
            for (int d = $urandom_range(0, 3); d > 0; d--) step();
            out_ready = 1'b1;
            checks++; if (ov_e !== 1'b1 || od_e !== exp_w || oe_e !== exp_e) begin errors++; $display("FAIL rand_e valid %b data %h err %b want 1 %h %b", ov_e, od_e, oe_e, exp_w, exp_e); end
            checks++; if (od_o !== exp_w || oe_o !== exp_o) begin errors++; $display("FAIL rand_o data %h err %b want %h %b", od_o, oe_o, exp_w, exp_o); end
            checks++; if (ec_e !== 8'(cnt_e) || ec_o !== 8'(cnt_o)) begin errors++; $display("FAIL rand_count got %0d/%0d want %0d/%0d", ec_e, ec_o, cnt_e, cnt_o); end
            step();
            checks++; if (ov_e !== 1'b0 || ir_e !== 1'b1) begin errors++; $display("FAIL rand_release valid %b ready %b want 0 1", ov_e, ir_e); end
        end
    endtask

    task automatic test_saturation();
        logic [DB-1:0] w;
        out_ready = 1'b1;
        send(8'h01, 1'b0, 1'b0);
        checks++; if (oe_o !== 1'b0 || oe_e !== 1'b1) begin errors++; $display("FAIL odd_01 err %b/%b want 0/1", oe_o, oe_e); end
        step();
        for (int k = 0; k < 257; k++) begin
            w = DB'($urandom);
            send(w, ^w, 1'b0);
            step();
        end
        checks++; if (ec_o !== 8'd255 || ec_o !== 8'(cnt_o)) begin errors++; $display("FAIL sat_odd got %0d want 255", ec_o); end
        checks++; if (ec_e !== 8'(cnt_e)) begin errors++; $display("FAIL sat_even got %0d want %0d", ec_e, cnt_e); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_frame();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
